// File: rtl/ahb_sram_slave.sv
// AHB-Lite style SRAM slave: word array with byte-lane writes, programmable
// wait states and a two-cycle ERROR response for misaligned/out-of-range accesses.
module ahb_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel_s,
    input  logic [31:0] hmaster_s,
    input  logic [31:0] haddr_s,
    input  logic [2:0]  hsize_s,
    input  logic [31:0] hwdata_s,
    input  logic        hwrite_s,
    output logic [31:0] hrdata_s,
    output logic        hready_s,
    output logic        hresp_s,
    output logic [31:0] err_master,
    output logic [31:0] err_addr
);

    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic [IDX_W-1:0]   ph_idx;
    logic [3:0]         ph_be;
    logic               ph_write;

    logic [31:0]        mem [MEM_WORDS];

    logic [31:0]        offset;
    logic               addr_err;
    logic [3:0]         be_new;
    logic [IDX_W-1:0]   idx_new;
    logic               accept;
    logic               commit;
    logic [31:0]        wr_word;
    logic [31:0]        fwd_word;

    // Address-phase decode: offset wraps at 32 bits, so addresses below base fault too
    always_comb begin
        offset   = haddr_s - BASE_ADDR;
        idx_new  = offset[IDX_W+1:2];
        addr_err = ({1'b0, offset} >= MEM_BYTES);
        be_new   = 4'b1111;
        case (hsize_s)
            3'd0: be_new = 4'b0001 << haddr_s[1:0];
            3'd1: begin
                be_new = haddr_s[1] ? 4'b1100 : 4'b0011;
                if (haddr_s[0]) addr_err = 1'b1;
            end
            3'd2: if (haddr_s[1:0] != 2'b00) addr_err = 1'b1;
            default: addr_err = 1'b1;
        endcase
    end

    // Write merge for the DONE cycle, plus forwarding for a back-to-back read of the same word
    always_comb begin
        accept = hsel_s && hready_s;
        commit = hresetn && (state == ST_DONE) && ph_write;
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = ph_be[i] ? hwdata_s[8*i +: 8] : mem[ph_idx][8*i +: 8];
        end
        fwd_word = (commit && (idx_new == ph_idx)) ? wr_word : mem[idx_new];
    end

    always_ff @(posedge hclk) begin
        if (commit) begin
            mem[ph_idx] <= wr_word;
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            hready_s   <= 1'b1;
            hresp_s    <= 1'b0;
            hrdata_s   <= 32'd0;
            err_master <= 32'd0;
            err_addr   <= 32'd0;
            ph_idx     <= '0;
            ph_be      <= 4'd0;
            ph_write   <= 1'b0;
        end else begin
            hrdata_s <= 32'd0;
            unique case (state)
                ST_WAIT: begin
                    if (cnt == 4'd1) begin
                        state    <= ST_DONE;
                        cnt      <= 4'd0;
                        hready_s <= 1'b1;
                        hresp_s  <= 1'b0;
                        hrdata_s <= ph_write ? 32'd0 : mem[ph_idx];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state    <= ST_ERR2;
                    hready_s <= 1'b1;
                    hresp_s  <= 1'b1;
                end
                default: begin
                    // IDLE, DONE and ERR2 all accept a new address phase
                    if (accept && addr_err) begin
                        state      <= ST_ERR1;
                        hready_s   <= 1'b0;
                        hresp_s    <= 1'b1;
                        err_master <= hmaster_s;
                        err_addr   <= haddr_s;
                        ph_write   <= 1'b0;
                        ph_be      <= 4'd0;
                    end else if (accept) begin
                        ph_idx   <= idx_new;
                        ph_be    <= be_new;
                        ph_write <= hwrite_s;
                        hresp_s  <= 1'b0;
                        if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            cnt      <= 4'(WAIT_STATES);
                            hready_s <= 1'b0;
                        end else begin
                            state    <= ST_DONE;
                            hready_s <= 1'b1;
                            hrdata_s <= hwrite_s ? 32'd0 : fwd_word;
                        end
                    end else begin
                        state    <= ST_IDLE;
                        hready_s <= 1'b1;
                        hresp_s  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 32'h0000_0000, byte base address of the array.
REQ-002 SHALL provide parameter MEM_WORDS, default 1024, number of 32-bit words (power of two, >=2).
REQ-003 SHALL provide parameter WAIT_STATES, default 1, number of hready_s-low cycles per OKAY transfer (0..15).
REQ-004 SHALL provide port hclk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL provide port hresetn, input, 1, reset, synchronous and active-low.
REQ-006 SHALL provide port hsel_s, input, 1, slave select; every selected cycle is a non-sequential transfer.
REQ-007 SHALL provide port hmaster_s, input, 32, requesting master ID.
REQ-008 SHALL provide port haddr_s, input, 32, byte address.
REQ-009 SHALL provide port hsize_s, input, 3, size code: 0 byte, 1 half-word, 2 word.
REQ-010 SHALL provide port hwdata_s, input, 32, write data, valid in the data phase.
REQ-011 SHALL provide port hwrite_s, input, 1, 1 write / 0 read.
REQ-012 SHALL provide port hrdata_s, output, 32, read data.
REQ-013 SHALL provide port hready_s, output, 1, transfer-complete / stall.
REQ-014 SHALL provide port hresp_s, output, 1, 0 OKAY / 1 ERROR.
REQ-015 SHALL provide port err_master, output, 32, hmaster_s of the most recent errored transfer.
REQ-016 SHALL provide port err_addr, output, 32, haddr_s of the most recent errored transfer.

Function
REQ-017 Address phase accepted iff hsel_s=1 and hready_s=1 on a rising edge; address, size, write and master registered.
REQ-018 Transfer errors iff hsize_s>2, half-word with haddr_s[0]=1, word with haddr_s[1:0]!=0, or (haddr_s-BASE_ADDR) >= 4*MEM_WORDS (unsigned, 32-bit wrap).
REQ-019 FSM states: IDLE, WAIT, DONE, ERR1, ERR2.
REQ-020 IDLE: hready_s=1, hresp_s=0; accepted OKAY transfer -> WAIT if WAIT_STATES>0, else DONE; accepted errored transfer -> ERR1.
REQ-021 WAIT: hready_s=0, hresp_s=0; down-counter loaded with WAIT_STATES at acceptance; -> DONE when counter reaches 1.
REQ-022 DONE: hready_s=1, hresp_s=0; transfer completes; a new accept this cycle -> WAIT/DONE/ERR1 per REQ-020; else IDLE.
REQ-023 ERR1: hready_s=0, hresp_s=1; always -> ERR2.
REQ-024 ERR2: hready_s=1, hresp_s=1; new accept allowed with same transitions as IDLE; else IDLE.
REQ-025 Write commits on the DONE edge using hwdata_s of that cycle; only addressed byte lanes written (little-endian: byte lane haddr[1:0], half lanes {haddr[1],0}+1..0, word all).
REQ-026 Read: hrdata_s = full word at registered index, valid in DONE; all other states hrdata_s=0.
REQ-027 Errored transfers SHALL NOT modify memory; err_master/err_addr updated at acceptance of an errored transfer.
REQ-028 Write followed back-to-back by read of same word SHALL return written data.
REQ-029 hsel_s deasserted during WAIT/ERR1 SHALL NOT abort the in-flight transfer.

Reset
REQ-030 hresetn=0 at a rising edge: state IDLE, counter 0, hready_s=1, hresp_s=0, hrdata_s=0, err_master=0, err_addr=0, registered phase cleared.
REQ-031 Reset mid-transfer SHALL abandon it with no memory write; memory contents are not reset.

Verification
REQ-032 WAIT_STATES=1: word write 0xDEADBEEF @0x10 then read @0x10 -> hready_s low 1 cycle each, hrdata_s=0xDEADBEEF in DONE, hresp_s=0.
REQ-033 Byte write 0xAA @0x13 onto word 0x11223344 -> subsequent word read returns 0xAA223344.
REQ-034 Word read @0x02 with hmaster_s=5 -> ERR1 (hready_s=0,hresp_s=1) then ERR2 (1,1); err_master=5, err_addr=0x02; memory unchanged.
REQ-035 Read @BASE_ADDR+4*MEM_WORDS -> two-cycle ERROR; @BASE_ADDR+4*MEM_WORDS-4 -> OKAY.
REQ-036 WAIT_STATES=0: back-to-back write 0x5 then read same word -> hready_s constantly 1, read returns 0x5.
REQ-037 hresetn low during WAIT of a write -> next cycle IDLE outputs per REQ-030; later read of that word returns pre-write value.
